// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: funct3 encodings, response
// ownership and the tag that follows each read into its response cycle.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_owner_e;

  typedef struct packed {
    rsp_owner_e  owner;
    logic [2:0]  funct3;
    logic [1:0]  offset;
  } resp_tag_t;

  // A D access is refused (error response, no memory traffic) when it is
  // misaligned for its size or uses an encoding that is not a legal
  // load/store width. Stores have no unsigned variants.
  function automatic logic d_access_bad(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic bad;
    case (funct3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = offset[0];
      3'b010:  bad = (offset != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | offset[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_load_formatter.sv
// Turns a raw aligned memory word into the RV32I load result selected by
// funct3 and the byte offset of the original address.
module load_formatter
  import mem_arb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half and extend it according to the load type
  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory read and write ports between instruction fetch and the
// load/store unit. All reads are issued as aligned words and formatted here;
// stores go straight to the write port in parallel with any fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_read_address,
  output logic        mem_write_mem,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  resp_tag_t        tag_q;
  logic             err_q;

  logic        rsp_returning;
  logic        d_bad;
  logic        d_load;
  logic        d_store;
  logic        store_stall;
  logic        if_wins;
  logic        d_load_gnt;
  logic        store_gnt;
  logic        d_load_rsp;
  logic [31:0] fmt_data;

  // IF is word aligned by contract, so its low address bits carry nothing
  logic unused_if_low;
  assign unused_if_low = ^if_addr[1:0];

  // Request classification and grant decisions for both ports
  always_comb begin
    rsp_returning = (tag_q.owner != RSP_NONE);
    d_bad         = d_req && d_access_bad(d_we, d_funct3, d_addr[1:0]);
    d_load        = d_req && !d_we && !d_bad;
    d_store       = d_req && d_we && !d_bad;
    // Memory formats its output with the live funct3, so only sw may share
    // a cycle with a returning read.
    store_stall   = d_store && rsp_returning && (d_funct3 != F3_SW);
    if_wins       = (starve_cnt == CNT_W'(STARVE_LIMIT));
    if_gnt        = !reset && if_req && (!d_load || if_wins);
    d_load_gnt    = !reset && d_load && !(if_req && if_wins);
    store_gnt     = !reset && d_store && !store_stall;
    d_gnt         = d_load_gnt || store_gnt || (!reset && d_bad);
  end

  // Drive the memory ports from whichever requester owns them this cycle
  always_comb begin
    mem_read_address  = if_gnt ? {if_addr[31:2], 2'b00} : {d_addr[31:2], 2'b00};
    mem_write_mem     = store_gnt;
    mem_write_address = d_addr;
    mem_write_data    = d_wdata;
    mem_funct3        = store_gnt ? d_funct3 : F3_LW;
  end

  // Count consecutive denied fetch cycles so IF eventually gets through
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (!if_wins) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Remember who issued this cycle's read and how to format its result
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '{owner: RSP_NONE, funct3: F3_LW, offset: 2'b00};
    end else if (if_gnt) begin
      tag_q <= '{owner: RSP_IF, funct3: F3_LW, offset: 2'b00};
    end else if (d_load_gnt) begin
      tag_q <= '{owner: RSP_D, funct3: d_funct3, offset: d_addr[1:0]};
    end else begin
      tag_q <= '{owner: RSP_NONE, funct3: F3_LW, offset: 2'b00};
    end
  end

  // One-cycle error pulse for refused D accesses
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= d_bad;
    end
  end

  load_formatter u_load_formatter (
    .word   (mem_read_data),
    .funct3 (tag_q.funct3),
    .offset (tag_q.offset),
    .result (fmt_data)
  );

  // Route the returning word to its owner; a reset in the response cycle drops it
  always_comb begin
    if_rvalid  = !reset && (tag_q.owner == RSP_IF);
    if_rdata   = if_rvalid ? fmt_data : 32'h0;
    d_load_rsp = !reset && (tag_q.owner == RSP_D);
    d_err      = !reset && err_q;
    d_rvalid   = d_load_rsp || d_err;
    d_rdata    = d_load_rsp ? fmt_data : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory model that has
// one-cycle registered reads and read-before-write behaviour.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_read_address;
  logic        mem_write_mem;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  logic [31:0] rd_word;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0]  LD_F3   [0:4] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
  localparam logic [31:0] LD_ADDR [0:4] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
  localparam logic [31:0] LD_EXP  [0:4] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
                                            32'hFFFF80FF, 32'h80FF0000};

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_gnt            (if_gnt),
    .if_rvalid         (if_rvalid),
    .if_rdata          (if_rdata),
    .d_req             (d_req),
    .d_we              (d_we),
    .d_funct3          (d_funct3),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_gnt             (d_gnt),
    .d_rvalid          (d_rvalid),
    .d_rdata           (d_rdata),
    .d_err             (d_err),
    .mem_read_address  (mem_read_address),
    .mem_write_mem     (mem_write_mem),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_funct3        (mem_funct3),
    .mem_read_data     (mem_read_data)
  );

  // Memory model: preloaded on reset, registered word read, byte/half/word writes
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) ^ 32'hA5A5_0000;
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'h11223344;
      rd_word <= 32'h0;
    end else begin
      rd_word <= mem[mem_read_address[7:2]];
      if (mem_write_mem) begin
        case (mem_funct3)
          3'b000:  mem[mem_write_address[7:2]][{mem_write_address[1:0], 3'b000} +: 8] <= mem_write_data[7:0];
          3'b001:  mem[mem_write_address[7:2]][{mem_write_address[1], 4'b0000} +: 16] <= mem_write_data[15:0];
          default: mem[mem_write_address[7:2]] <= mem_write_data;
        endcase
      end
    end
  end

  // The memory only returns the plain word when funct3 is 010 in the response cycle
  assign mem_read_data = (mem_funct3 == 3'b010) ? rd_word : 32'hBAD0BAD0;

  task idle_inputs;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_funct3 = 3'b010;
    d_addr   = 32'h0;
    d_wdata  = 32'h0;
  endtask

  task test_reset;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h21; d_wdata = 32'hAB;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (if_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_if_gnt: got %b expected 0", if_gnt); end
    n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_d_gnt: got %b expected 0", d_gnt); end
    n_checks++; if (mem_write_mem !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_write_mem: got %b expected 0", mem_write_mem); end
    n_checks++; if (mem_funct3 !== 3'b010) begin n_fail++; $display("[TB] FAIL reset_funct3: got %b expected 010", mem_funct3); end
    n_checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || d_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valids: got %b%b%b expected 000", if_rvalid, d_rvalid, d_err); end
    n_checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, d_rdata); end
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_rvalid: got %b%b expected 00", if_rvalid, d_rvalid); end
  endtask

  task test_if_read;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL if_gnt: got %b expected 1", if_gnt); end
    n_checks++; if (mem_read_address !== 32'h10) begin n_fail++; $display("[TB] FAIL if_read_addr: got %h expected 00000010", mem_read_address); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    n_checks++; if (if_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL if_rvalid: got %b expected 1", if_rvalid); end
    n_checks++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL if_rdata: got %h expected deadbeef", if_rdata); end
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL if_no_d_rvalid: got %b expected 0", d_rvalid); end
    @(negedge clk);
    #1;
    n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL if_rvalid_drop: got %b expected 0", if_rvalid); end
  endtask

  task test_d_load_format;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h10; d_wdata = 32'h80FF0000;
    #1;
    n_checks++; if (d_gnt !== 1'b1 || mem_write_mem !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_setup: got gnt=%b we=%b expected 1/1", d_gnt, mem_write_mem); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_funct3 = LD_F3[i]; d_addr = LD_ADDR[i]; d_wdata = 32'h0;
      #1;
      n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL load%0d_gnt: got %b expected 1", i, d_gnt); end
      @(negedge clk);
      d_req = 1'b0;
      #1;
      n_checks++; if (d_rvalid !== 1'b1 || d_err !== 1'b0) begin n_fail++; $display("[TB] FAIL load%0d_rvalid: got rvalid=%b err=%b expected 1/0", i, d_rvalid, d_err); end
      n_checks++; if (d_rdata !== LD_EXP[i]) begin n_fail++; $display("[TB] FAIL load%0d_rdata: got %h expected %h", i, d_rdata, LD_EXP[i]); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task test_starvation;
    logic exp_if;
    logic exp_prev_if;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_if = ((i % 5) == 4);
      n_checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin n_fail++; $display("[TB] FAIL starve_cycle%0d: got if=%b d=%b expected if=%b d=%b", i, if_gnt, d_gnt, exp_if, !exp_if); end
      if (i > 0) begin
        exp_prev_if = (((i - 1) % 5) == 4);
        n_checks++; if (if_rvalid !== exp_prev_if || d_rvalid !== !exp_prev_if) begin n_fail++; $display("[TB] FAIL starve_rsp%0d: got if=%b d=%b expected if=%b d=%b", i, if_rvalid, d_rvalid, exp_prev_if, !exp_prev_if); end
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task test_store_stall;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h24;
    #1;
    n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_if_gnt: got %b expected 1", if_gnt); end
    @(negedge clk);
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h21; d_wdata = 32'h000000AB;
    #1;
    n_checks++; if (d_gnt !== 1'b0 || mem_write_mem !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_stall: got gnt=%b we=%b expected 0/0", d_gnt, mem_write_mem); end
    n_checks++; if (mem_funct3 !== 3'b010) begin n_fail++; $display("[TB] FAIL sb_stall_funct3: got %b expected 010", mem_funct3); end
    n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A50009) begin n_fail++; $display("[TB] FAIL stall_if_rdata: got %b/%h expected 1/a5a50009", if_rvalid, if_rdata); end
    @(negedge clk);
    #1;
    n_checks++; if (d_gnt !== 1'b1 || mem_write_mem !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_gnt: got gnt=%b we=%b expected 1/1", d_gnt, mem_write_mem); end
    n_checks++; if (mem_funct3 !== 3'b000) begin n_fail++; $display("[TB] FAIL sb_funct3: got %b expected 000", mem_funct3); end
    n_checks++; if (mem_write_address !== 32'h21 || mem_write_data !== 32'hAB) begin n_fail++; $display("[TB] FAIL sb_wr_bus: got %h/%h expected 00000021/000000ab", mem_write_address, mem_write_data); end
    @(negedge clk);
    d_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h20;
    #1;
    n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL readback_gnt: got %b expected 1", if_gnt); end
    @(negedge clk);
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h24; d_wdata = 32'hCAFEF00D;
    #1;
    n_checks++; if (if_rdata !== 32'h1122AB44) begin n_fail++; $display("[TB] FAIL sb_readback: got %h expected 1122ab44", if_rdata); end
    n_checks++; if (d_gnt !== 1'b1 || mem_write_mem !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_no_stall: got gnt=%b we=%b expected 1/1", d_gnt, mem_write_mem); end
    n_checks++; if (mem_funct3 !== 3'b010) begin n_fail++; $display("[TB] FAIL sw_funct3: got %b expected 010", mem_funct3); end
    @(negedge clk);
    idle_inputs();
  endtask

  task test_misaligned;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h24;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h06;
    #1;
    n_checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_gnts: got d=%b if=%b expected 1/1", d_gnt, if_gnt); end
    n_checks++; if (mem_read_address !== 32'h24 || mem_write_mem !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_no_access: got %h/%b expected 00000024/0", mem_read_address, mem_write_mem); end
    @(negedge clk);
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b001; d_addr = 32'h13;
    #1;
    n_checks++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL lw_mis_rsp: got %b/%b/%h expected 1/1/00000000", d_rvalid, d_err, d_rdata); end
    n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL mis_if_rdata: got %b/%h expected 1/cafef00d", if_rvalid, if_rdata); end
    n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL lh_odd_gnt: got %b expected 1", d_gnt); end
    @(negedge clk);
    d_funct3 = 3'b011; d_addr = 32'h10;
    #1;
    n_checks++; if (d_err !== 1'b1 || d_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL lh_odd_err: got err=%b gnt=%b expected 1/1", d_err, d_gnt); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    n_checks++; if (d_err !== 1'b1 || d_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_f3_err: got err=%b rvalid=%b expected 1/1", d_err, d_rvalid); end
    @(negedge clk);
    #1;
    n_checks++; if (d_err !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clears: got err=%b rvalid=%b expected 0/0", d_err, d_rvalid); end
    idle_inputs();
  endtask

  task test_reset_drop;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h10;
    #1;
    n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_gnt: got %b expected 1", d_gnt); end
    @(negedge clk);
    d_req = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || d_err !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_in_reset: got %b/%h/%b expected 0/00000000/0", d_rvalid, d_rdata, d_err); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_after_reset: got d=%b if=%b expected 0/0", d_rvalid, if_rvalid); end
    n_checks++; if (mem_write_mem !== 1'b0 || mem_funct3 !== 3'b010 || d_gnt !== 1'b0 || if_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_idle_outputs: got we=%b f3=%b dg=%b ig=%b expected 0/010/0/0", mem_write_mem, mem_funct3, d_gnt, if_gnt); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    $display("[TB] mem_port_arbiter directed test start");
    test_reset();
    test_if_read();
    test_d_load_format();
    test_starvation();
    test_store_stall();
    test_misaligned();
    test_reset_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
